// File: rtl/dmem_dma_arbiter_pkg.sv
// Shared types and sizing helpers for the data-memory DMA arbiter.
package dmem_dma_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_e;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// First-word-fall-through response FIFO; head is read straight from the storage registers.
module dmem_rsp_fifo
  import dmem_dma_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [occ_width(DEPTH)-1:0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  pop;

  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Upstream credit accounting must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) push |-> (occ < OCC_W'(DEPTH)));

endmodule

// File: rtl/dmem_dma_arbiter.sv
// Round-robin, burst-limited sharing of the data-memory DMA port between a write and a read engine.
//   state    | meaning
//   OWN_NONE | no beat granted last cycle
//   OWN_WR   | write engine granted last cycle
//   OWN_RD   | read engine granted last cycle
module dmem_dma_arbiter
  import dmem_dma_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int BURST      = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  core_reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  data_dma_en,
  output logic                  data_dma_ren,
  output logic [STRB_WIDTH-1:0] data_dma_wen,
  output logic [ADDR_WIDTH-1:0] data_dma_addr,
  output logic [DATA_WIDTH-1:0] data_dma_wr_data,
  input  logic [DATA_WIDTH-1:0] data_dma_rd_data,
  output logic                  busy
);

  localparam int OCC_W = occ_width(RSP_DEPTH);
  localparam int CR_W  = OCC_W + 1;
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

  owner_e           owner;
  owner_e           last;
  owner_e           grant;
  logic [CNT_W-1:0] cnt;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [CR_W-1:0]  credit_used;
  logic             pop;
  logic             wr_elig;
  logic             rd_elig;
  logic             cnt_ok;

  // Slots already spoken for: stored responses plus the one in flight, less the one leaving now.
  assign pop         = rd_rsp_valid && rd_rsp_ready;
  assign credit_used = CR_W'(occ) + CR_W'(inflight) - CR_W'(pop);
  assign wr_elig     = !core_reset && wr_valid;
  assign rd_elig     = !core_reset && rd_cmd_valid && (credit_used < CR_W'(RSP_DEPTH));
  assign cnt_ok      = (cnt < BURST_CNT);

  always_comb begin
    grant = OWN_NONE;
    case (owner)
      OWN_WR: begin
        if (wr_elig && (cnt_ok || !rd_elig)) grant = OWN_WR;
        else if (rd_elig)                    grant = OWN_RD;
      end
      OWN_RD: begin
        if (rd_elig && (cnt_ok || !wr_elig)) grant = OWN_RD;
        else if (wr_elig)                    grant = OWN_WR;
      end
      default: begin
        if (wr_elig && rd_elig) grant = (last == OWN_WR) ? OWN_RD : OWN_WR;
        else if (wr_elig)       grant = OWN_WR;
        else if (rd_elig)       grant = OWN_RD;
      end
    endcase
  end

  always_comb begin
    wr_ready         = (grant == OWN_WR);
    rd_cmd_ready     = (grant == OWN_RD);
    data_dma_en      = 1'b0;
    data_dma_ren     = 1'b0;
    data_dma_wen     = '0;
    data_dma_addr    = '0;
    data_dma_wr_data = '0;
    case (grant)
      OWN_WR: begin
        data_dma_en      = 1'b1;
        data_dma_wen     = wr_strb;
        data_dma_addr    = wr_addr;
        data_dma_wr_data = wr_data;
      end
      OWN_RD: begin
        data_dma_en   = 1'b1;
        data_dma_ren  = 1'b1;
        data_dma_addr = rd_cmd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (core_reset) begin
      owner    <= OWN_NONE;
      last     <= OWN_RD;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= (grant == OWN_RD);
      if (grant != OWN_NONE) begin
        owner <= grant;
        last  <= grant;
        if (grant == owner) cnt <= (cnt == BURST_CNT) ? cnt : cnt + CNT_W'(1);
        else                cnt <= CNT_W'(1);
      end else begin
        owner <= OWN_NONE;
        cnt   <= '0;
      end
    end
  end

  dmem_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (core_reset),
    .push      (inflight),
    .push_data (data_dma_rd_data),
    .out_ready (rd_rsp_ready),
    .out_valid (rd_rsp_valid),
    .out_data  (rd_rsp_data),
    .occ       (occ)
  );

  assign busy = inflight || (occ != '0);

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Scoreboard bench: a line-level memory contract predicts read data; a negedge monitor checks port and responses.
module tb_dmem_dma_arbiter;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int SW = 8;
  localparam int DEPTH = 4;
  localparam logic [63:0] D0 = 64'h1122334455667788;

  logic          clk = 1'b0;
  logic          core_reset;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] wr_data;
  logic          rd_cmd_valid, rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic          data_dma_en, data_dma_ren;
  logic [SW-1:0] data_dma_wen;
  logic [AW-1:0] data_dma_addr;
  logic [DW-1:0] data_dma_wr_data;
  logic [DW-1:0] data_dma_rd_data;
  logic          busy;

  always #5 clk = ~clk;

  dmem_dma_arbiter #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .STRB_WIDTH (SW), .BURST (4), .RSP_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .core_reset (core_reset),
    .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr), .wr_strb (wr_strb), .wr_data (wr_data),
    .rd_cmd_valid (rd_cmd_valid), .rd_cmd_ready (rd_cmd_ready), .rd_cmd_addr (rd_cmd_addr),
    .rd_rsp_valid (rd_rsp_valid), .rd_rsp_ready (rd_rsp_ready), .rd_rsp_data (rd_rsp_data),
    .data_dma_en (data_dma_en), .data_dma_ren (data_dma_ren), .data_dma_wen (data_dma_wen),
    .data_dma_addr (data_dma_addr), .data_dma_wr_data (data_dma_wr_data),
    .data_dma_rd_data (data_dma_rd_data), .busy (busy)
  );

  // The memory itself, driven only by the DUT port; garbage on non-read cycles.
  logic [63:0] ram     [32];
  logic [63:0] ref_mem [32];

  always @(posedge clk) begin
    if (data_dma_en && data_dma_ren) data_dma_rd_data <= ram[data_dma_addr[7:3]];
    else                             data_dma_rd_data <= {$urandom, $urandom};
    if (data_dma_en && !data_dma_ren)
      for (int b = 0; b < SW; b++)
        if (data_dma_wen[b]) ram[data_dma_addr[7:3]][b*8 +: 8] <= data_dma_wr_data[b*8 +: 8];
  end

  int n_pass = 0;
  int n_total = 0;
  int rd_acc = 0;
  int rd_pops = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every cycle, check the port against the arbitration contract and score responses.
  always @(negedge clk) begin
    logic pop_now, rd_el;
    int   outstanding;
    logic [63:0] e;
    if (core_reset) begin
      exp_q.delete();
      chk("rst_no_grant", !wr_ready && !rd_cmd_ready, {wr_ready, rd_cmd_ready}, 0);
    end else begin
      pop_now     = rd_rsp_valid && rd_rsp_ready;
      outstanding = exp_q.size();
      rd_el       = rd_cmd_valid && ((outstanding - int'(pop_now)) < DEPTH);
      chk("busy", busy == (outstanding != 0), busy, outstanding != 0);
      chk("one_grant", !(wr_ready && rd_cmd_ready), {wr_ready, rd_cmd_ready}, 0);
      chk("grant_legal", (!wr_ready || wr_valid) && (!rd_cmd_ready || rd_el), {wr_ready, rd_cmd_ready}, {wr_valid, rd_el});
      chk("work_conserving", (wr_valid || rd_el) == (wr_ready || rd_cmd_ready), {wr_ready, rd_cmd_ready}, {wr_valid, rd_el});
      if (pop_now) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1'b0, rd_rsp_data, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", rd_rsp_data == e, rd_rsp_data, e);
        end
        rd_pops++;
      end
      if (wr_ready) begin
        chk("wr_port", data_dma_en && !data_dma_ren && data_dma_wen == wr_strb && data_dma_addr == wr_addr
            && data_dma_wr_data == wr_data, {data_dma_en, data_dma_ren, data_dma_addr, data_dma_wen},
            {2'b10, wr_addr, wr_strb});
        for (int b = 0; b < SW; b++)
          if (wr_strb[b]) ref_mem[wr_addr[7:3]][b*8 +: 8] = wr_data[b*8 +: 8];
      end else if (rd_cmd_ready) begin
        chk("rd_port", data_dma_en && data_dma_ren && data_dma_wen == '0 && data_dma_addr == rd_cmd_addr,
            {data_dma_en, data_dma_ren, data_dma_addr, data_dma_wen}, {2'b11, rd_cmd_addr, 8'h00});
        exp_q.push_back(ref_mem[rd_cmd_addr[7:3]]);
        rd_acc++;
      end else begin
        chk("idle_port", !data_dma_en && !data_dma_ren && data_dma_wen == '0 && data_dma_addr == '0
            && data_dma_wr_data == '0, {data_dma_en, data_dma_ren, data_dma_addr}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    wr_addr     = {8'h00, 5'($urandom), 3'b000};
    wr_strb     = 8'($urandom);
    wr_data     = {$urandom, $urandom};
    rd_cmd_addr = {8'h00, 5'($urandom), 3'b000};
  endtask

  task automatic do_reset();
    core_reset = 1'b1;
    repeat (2) step();
    core_reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    wr_valid = 1'b0; rd_cmd_valid = 1'b0; rd_rsp_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin step(); n++; end
    chk("drain_timeout", n < 50, exp_q.size(), 0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] s, input logic [63:0] d);
    wr_addr = a; wr_strb = s; wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    chk("dw_grant", wr_ready && data_dma_en && !data_dma_ren && data_dma_wen == s, {wr_ready, data_dma_wen}, {1'b1, s});
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_read_check(input logic [15:0] a, input logic [63:0] d);
    rd_cmd_addr = a; rd_cmd_valid = 1'b1; rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("dr_accept", rd_cmd_ready, rd_cmd_ready, 1);
    step();
    rd_cmd_valid = 1'b0;
    @(negedge clk);
    chk("dr_lat_t1", !rd_rsp_valid, rd_rsp_valid, 0);
    @(negedge clk);
    chk("dr_lat_t2", rd_rsp_valid && rd_rsp_data == d, rd_rsp_data, d);
    step();
  endtask

  initial begin
    int base_acc, base_pop, n;
    bit exp_w;
    for (int i = 0; i < 32; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    core_reset = 1'b1; wr_valid = 1'b0; rd_cmd_valid = 1'b0; rd_rsp_ready = 1'b0;
    wr_addr = '0; wr_strb = '0; wr_data = '0; rd_cmd_addr = '0;
    step();
    wr_valid = 1'b1; rd_cmd_valid = 1'b1; rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset_state", !wr_ready && !rd_cmd_ready && !rd_rsp_valid && !busy && rd_rsp_data == '0 && !data_dma_en
        && !data_dma_ren && data_dma_wen == '0 && data_dma_addr == '0 && data_dma_wr_data == '0,
        {wr_ready, rd_cmd_ready, rd_rsp_valid, busy, data_dma_en}, 0);
    step();
    wr_valid = 1'b0; rd_cmd_valid = 1'b0;
    step();
    core_reset = 1'b0;

    do_write(16'h0040, 8'hFF, D0);
    chk("ram_line8", ram[8] == D0, ram[8], D0);
    do_write(16'h0048, 8'h00, 64'hDEAD_BEEF_0000_0001);
    chk("ram_zero_strb", ram[9] == 64'h0, ram[9], 0);
    do_read_check(16'h0040, D0);

    // Burst fairness from a fresh reset: WR wins the first tie, then 4-beat alternation.
    do_reset();
    rd_rsp_ready = 1'b1; wr_valid = 1'b1; rd_cmd_valid = 1'b1;
    rand_fields();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_w = ((k / 4) % 2) == 0;
      chk("burst_order", wr_ready == exp_w && rd_cmd_ready == !exp_w, {wr_ready, rd_cmd_ready}, {exp_w, !exp_w});
      step();
      rand_fields();
    end
    drain();

    // Credit limit with a stalled consumer.
    rd_rsp_ready = 1'b0; rd_cmd_valid = 1'b1;
    base_acc = rd_acc;
    repeat (10) begin step(); rand_fields(); end
    chk("credit_fill", rd_acc - base_acc == DEPTH, rd_acc - base_acc, DEPTH);
    @(negedge clk);
    chk("credit_block", !rd_cmd_ready, rd_cmd_ready, 0);
    step();
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("credit_pop_grant", rd_cmd_ready, rd_cmd_ready, 1);
    step();
    rd_rsp_ready = 1'b0;
    @(negedge clk);
    chk("credit_reblock", !rd_cmd_ready, rd_cmd_ready, 0);
    #1;
    chk("credit_one_more", rd_acc - base_acc == DEPTH + 1, rd_acc - base_acc, DEPTH + 1);
    step();
    rd_rsp_ready = 1'b1;
    n = 0;
    while (rd_acc - base_acc < 8 && n < 40) begin step(); rand_fields(); n++; end
    rd_cmd_valid = 1'b0;
    chk("credit_rest", rd_acc - base_acc == 8, rd_acc - base_acc, 8);
    drain();

    // Streaming reads at one per cycle.
    base_acc = rd_acc; base_pop = rd_pops;
    rd_rsp_ready = 1'b1; rd_cmd_valid = 1'b1;
    rand_fields();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      chk("stream_accept", rd_cmd_ready, rd_cmd_ready, 1);
      chk("stream_occ", exp_q.size() <= 2, exp_q.size(), 2);
      step();
      rand_fields();
    end
    rd_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("stream_pops", rd_pops - base_pop == 16 && rd_acc - base_acc == 16, rd_pops - base_pop, 16);
    drain();

    // Reset while a read is in flight.
    do_write(16'h0040, 8'hFF, D0);
    base_pop = rd_pops;
    rd_cmd_addr = 16'h0040; rd_cmd_valid = 1'b1; rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_rd_accept", rd_cmd_ready, rd_cmd_ready, 1);
    step();
    rd_cmd_valid = 1'b0; core_reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst_flush", !rd_rsp_valid, rd_rsp_valid, 0);
    step();
    core_reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", !rd_rsp_valid && !busy, {rd_rsp_valid, busy}, 0);
      step();
    end
    chk("rst_no_rsp", rd_pops == base_pop, rd_pops - base_pop, 0);
    do_write(16'h0040, 8'hFF, D0);
    do_read_check(16'h0040, D0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      wr_valid     = ($urandom_range(1, 0) == 1);
      rd_cmd_valid = ($urandom_range(1, 0) == 1);
      rd_rsp_ready = ($urandom_range(9, 0) < 7);
      rand_fields();
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
